ex_div: RTL



---
 rtl/ex_div.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// rtl/ex_div.sv - execute stage: single-cycle logic ops plus iterative 32-cycle DIV/DIVU
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   aluop_i, alusel_i        operation subtype / class from ID/EX
//   reg1_i, reg2_i           operands (dividend / divisor for divides)
//   wd_i, wreg_i             write-back destination and enable from ID/EX
//   wd_o, wreg_o, wdata_o    write-back triple to EX/MEM and ID forwarding
//   stallreq_o               high while the divider holds the pipeline
//
// Build option: define EX_DIV_SIGNED_EN to support signed DIV (8'h1A).
// Without it, 8'h1A is an unknown op and the sign logic is absent.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o
);
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_DIVU = 8'h1B;
`ifdef EX_DIV_SIGNED_EN
    localparam logic [7:0] OP_DIV  = 8'h1A;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] rem_q, rem_d;
    logic        dz_q, dz_d;       // divide-by-zero result pending

    logic        is_div;
    logic [31:0] mag1, mag2;
    logic [32:0] rem_sh, diff;
    logic [31:0] div_result;

`ifdef EX_DIV_SIGNED_EN
    logic is_sdiv;
    logic neg_q, neg_d;            // quotient sign correction latched at start
    assign is_sdiv = (aluop_i == OP_DIV);
    assign is_div  = is_sdiv || (aluop_i == OP_DIVU);
    assign mag1    = (is_sdiv && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign mag2    = (is_sdiv && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    assign div_result = dz_q  ? 32'hFFFF_FFFF :
                        neg_q ? (~dvd_q + 32'd1) : dvd_q;
`else
    assign is_div  = (aluop_i == OP_DIVU);
    assign mag1    = reg1_i;
    assign mag2    = reg2_i;
    assign div_result = dz_q ? 32'hFFFF_FFFF : dvd_q;
`endif

    // Restoring step. The shifted remainder needs 33 bits when the divisor
    // exceeds 2^31; after a successful subtract it always fits back in 32.
    assign rem_sh = {rem_q, dvd_q[31]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
`ifdef EX_DIV_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
`ifdef EX_DIV_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
`ifdef EX_DIV_SIGNED_EN
        neg_d   = neg_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    if (reg2_i == 32'd0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        dz_d    = 1'b0;
                        dvd_d   = mag1;
                        dvs_d   = mag2;
                        rem_d   = '0;
                        cnt_d   = '0;
`ifdef EX_DIV_SIGNED_EN
                        neg_d   = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
`endif
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    dvd_d = {dvd_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_sh[31:0];
                    dvd_d = {dvd_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        if (rst) begin
            wd_o   = '0;
            wreg_o = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_div) begin
                        stallreq_o = 1'b1;
                        wreg_o     = 1'b0;
                    end else if (alusel_i == SEL_LOGIC) begin
                        case (aluop_i)
                            OP_AND:  wdata_o = reg1_i & reg2_i;
                            OP_OR:   wdata_o = reg1_i | reg2_i;
                            OP_XOR:  wdata_o = reg1_i ^ reg2_i;
                            OP_NOR:  wdata_o = ~(reg1_i | reg2_i);
                            default: wdata_o = '0;
                        endcase
                    end
                end
                S_BUSY: begin
                    stallreq_o = 1'b1;
                    wreg_o     = 1'b0;
                end
                S_DONE: begin
                    wdata_o = div_result;
                end
                default: begin
                    wreg_o = 1'b0;
                end
            endcase
        end
    end
endmodule
